// File: rtl/audio_sample_stream_pkg.sv
// Shared constants and FSM state type for the audio sample streamer.
// Constants here are the defaults for the module parameters.
package audio_pkg;
    localparam int          MEM_SIZE     = 250000;
    localparam int          HEADER_BYTES = 44;
    localparam int          ADDR_W       = 18;
    localparam int          FRAC_W       = 4;
    localparam logic [7:0]  SILENCE      = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;
endpackage

// File: rtl/audio_sample_stream_if.sv
// ROM read port plus sample valid/ready handshake toward the PWM stage.
interface audio_sample_stream_if #(
    parameter int ADDR_W = audio_pkg::ADDR_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        sample_out;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output mem_addr, sample_out, sample_valid,
        input  mem_rdata, sample_ready
    );
    modport slave (
        input  mem_addr, sample_out, sample_valid,
        output mem_rdata, sample_ready
    );
endinterface

// File: rtl/audio_sample_stream_phase_acc.sv
// Fixed-point playback position: integer part addresses the ROM, 4 fraction bits
// allow non-integer speeds. Wraps back to the first byte after the WAV header.
module audio_phase_acc #(
    parameter int MEM_SIZE     = audio_pkg::MEM_SIZE,
    parameter int HEADER_BYTES = audio_pkg::HEADER_BYTES,
    parameter int ADDR_W       = audio_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              clear,
    input  logic [7:0]        speed,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);
    import audio_pkg::*;

    localparam int                POS_W = ADDR_W + FRAC_W;
    localparam logic [POS_W-1:0]  HOME  = {ADDR_W'(HEADER_BYTES), FRAC_W'(0)};
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(MEM_SIZE);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W:0]   sum;

    // One guard bit on the sum so a large step near the end cannot alias low.
    always_comb begin
        sum   = {1'b0, pos_q} + {{(POS_W + 1 - 8){1'b0}}, speed};
        wrap  = step && !clear && (sum[POS_W:FRAC_W] >= LIMIT);
        pos_d = pos_q;
        if (clear || wrap)
            pos_d = HOME;
        else if (step)
            pos_d = sum[POS_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pos_q <= HOME;
        else        pos_q <= pos_d;
    end

    assign addr = pos_q[POS_W-1:FRAC_W];
endmodule

// File: rtl/audio_sample_stream.sv
// Tick-driven ROM sample streamer: fetch one byte per accepted tick, present it
// on a valid/ready handshake, flag ticks that arrive while still busy.
module audio_sample_stream #(
    parameter int MEM_SIZE     = audio_pkg::MEM_SIZE,
    parameter int HEADER_BYTES = audio_pkg::HEADER_BYTES,
    parameter int ADDR_W       = audio_pkg::ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         restart,
    input  logic [7:0]                   speed,
    input  logic                         sample_tick,
    output logic                         loop_pulse,
    output logic                         overrun,
    audio_sample_stream_if.master        bus
);
    import audio_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              loop_q, loop_d;
    logic              step;
    logic              wrap;
    logic [ADDR_W-1:0] pos_addr;

    audio_phase_acc #(
        .MEM_SIZE     (MEM_SIZE),
        .HEADER_BYTES (HEADER_BYTES),
        .ADDR_W       (ADDR_W)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step),
        .clear (restart),
        .speed (speed),
        .addr  (pos_addr),
        .wrap  (wrap)
    );

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        sample_d   = sample_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        step       = 1'b0;
        loop_d     = wrap;
        if (restart) begin
            // A tick coinciding with restart is simply dropped.
            state_d   = ST_IDLE;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (sample_tick && state_q != ST_IDLE)
                overrun_d = 1'b1;
            case (state_q)
                ST_IDLE: if (sample_tick && enable) begin
                    mem_addr_d = pos_addr;
                    step       = 1'b1;
                    state_d    = ST_FETCH;
                end
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    sample_d = bus.mem_rdata;
                    valid_d  = 1'b1;
                    state_d  = ST_PRESENT;
                end
                ST_PRESENT: if (bus.sample_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= ADDR_W'(HEADER_BYTES);
            sample_q   <= SILENCE;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            loop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            loop_q     <= loop_d;
        end
    end

    assign bus.mem_addr     = mem_addr_q;
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign loop_pulse       = loop_q;
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_audio_sample_stream.sv
// Directed bench for audio_sample_stream with a 1-cycle-latency ROM model.
module tb_audio_sample_stream;
    localparam int AW = 18;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] speed = 8'h10;
    logic       sample_tick = 1'b0;
    logic       loop_pulse;
    logic       overrun;
    int         checks = 0;
    int         failures = 0;
    int         loop_cnt = 0;

    audio_sample_stream_if #(.ADDR_W(AW)) bus ();

    audio_sample_stream #(.MEM_SIZE(64), .HEADER_BYTES(44), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .restart     (restart),
        .speed       (speed),
        .sample_tick (sample_tick),
        .loop_pulse  (loop_pulse),
        .overrun     (overrun),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input logic [AW-1:0] a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    always @(posedge clk) bus.mem_rdata <= rom_val(bus.mem_addr);
    always @(negedge clk) if (loop_pulse) loop_cnt++;

    // Pulse one tick, then wait (bounded) for the resulting sample; lat = -1 on timeout.
    task automatic tick_collect(output logic [AW-1:0] a, output logic [7:0] d, output int lat);
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        a = bus.mem_addr; d = 8'h00; lat = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.sample_valid) begin lat = i + 2; d = bus.sample_out; break; end
        end
    endtask

    task automatic pulse_restart();
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_addr !== 18'd44) begin failures++; $display("FAIL reset_addr got=%0d exp=44", bus.mem_addr); end
        checks++; if (bus.sample_out !== 8'h80) begin failures++; $display("FAIL reset_sample got=%h exp=80", bus.sample_out); end
        checks++; if (bus.sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.sample_valid); end
        checks++; if (loop_pulse !== 1'b0) begin failures++; $display("FAIL reset_loop got=%b exp=0", loop_pulse); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        rst_n = 1'b1;
    endtask

    task automatic test_unity();
        logic [AW-1:0] a; logic [7:0] d; int lat;
        logic [AW-1:0] exp_a [3] = '{18'd44, 18'd45, 18'd46};
        enable = 1'b1; speed = 8'h10; bus.sample_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick_collect(a, d, lat);
            checks++; if (a !== exp_a[k]) begin failures++; $display("FAIL unity_addr%0d got=%0d exp=%0d", k, a, exp_a[k]); end
            checks++; if (lat !== 3) begin failures++; $display("FAIL unity_latency%0d got=%0d exp=3", k, lat); end
            checks++; if (d !== rom_val(exp_a[k])) begin failures++; $display("FAIL unity_data%0d got=%h exp=%h", k, d, rom_val(exp_a[k])); end
        end
    endtask

    task automatic test_frac_speed();
        logic [AW-1:0] a; logic [7:0] d; int lat;
        logic [AW-1:0] exp_a [5] = '{18'd44, 18'd45, 18'd47, 18'd48, 18'd50};
        pulse_restart();
        speed = 8'h18;
        for (int k = 0; k < 5; k++) begin
            tick_collect(a, d, lat);
            checks++; if (a !== exp_a[k]) begin failures++; $display("FAIL frac_addr%0d got=%0d exp=%0d", k, a, exp_a[k]); end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a; logic [7:0] d; int lat; int c0;
        pulse_restart();
        speed = 8'hF0; tick_collect(a, d, lat);   // 44 -> 59
        speed = 8'h40; tick_collect(a, d, lat);   // 59 -> 63
        checks++; if (a !== 18'd59) begin failures++; $display("FAIL wrap_pre got=%0d exp=59", a); end
        speed = 8'h10; c0 = loop_cnt;
        tick_collect(a, d, lat);
        checks++; if (a !== 18'd63) begin failures++; $display("FAIL wrap_last got=%0d exp=63", a); end
        checks++; if (d !== rom_val(18'd63)) begin failures++; $display("FAIL wrap_data got=%h exp=%h", d, rom_val(18'd63)); end
        tick_collect(a, d, lat);
        checks++; if (a !== 18'd44) begin failures++; $display("FAIL wrap_home got=%0d exp=44", a); end
        checks++; if (loop_cnt - c0 !== 1) begin failures++; $display("FAIL wrap_loop_count got=%0d exp=1", loop_cnt - c0); end
        // Largest step from 59 overshoots well past the end and must still wrap.
        pulse_restart();
        speed = 8'hF0; tick_collect(a, d, lat);
        speed = 8'hFF; tick_collect(a, d, lat);
        tick_collect(a, d, lat);
        checks++; if (a !== 18'd44) begin failures++; $display("FAIL wrap_ff got=%0d exp=44", a); end
    endtask

    task automatic test_overrun();
        logic [AW-1:0] a; logic [7:0] d; int lat;
        pulse_restart();
        speed = 8'h10; bus.sample_ready = 1'b0;
        tick_collect(a, d, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL ovr_first_latency got=%0d exp=3", lat); end
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        checks++; if (bus.sample_out !== rom_val(18'd44)) begin failures++; $display("FAIL ovr_hold got=%h exp=%h", bus.sample_out, rom_val(18'd44)); end
        checks++; if (bus.sample_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_hold got=%b exp=1", bus.sample_valid); end
        bus.sample_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.sample_valid !== 1'b0) begin failures++; $display("FAIL ovr_valid_drop got=%b exp=0", bus.sample_valid); end
        tick_collect(a, d, lat);
        checks++; if (a !== 18'd45) begin failures++; $display("FAIL ovr_single_advance got=%0d exp=45", a); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        pulse_restart();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_restart_tick();
        logic [AW-1:0] a; logic [7:0] d; int lat;
        speed = 8'h10;
        tick_collect(a, d, lat);                  // pos now 45
        @(negedge clk); restart = 1'b1; sample_tick = 1'b1;
        @(negedge clk); restart = 1'b0; sample_tick = 1'b0;
        checks++; if (bus.sample_valid !== 1'b0) begin failures++; $display("FAIL rt_valid got=%b exp=0", bus.sample_valid); end
        tick_collect(a, d, lat);
        checks++; if (a !== 18'd44) begin failures++; $display("FAIL rt_addr got=%0d exp=44", a); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rt_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_speed_zero();
        logic [AW-1:0] a0, a1; logic [7:0] d0, d1; int lat;
        pulse_restart();
        speed = 8'h00;
        tick_collect(a0, d0, lat);
        tick_collect(a1, d1, lat);
        checks++; if (a1 !== 18'd44) begin failures++; $display("FAIL hold_addr got=%0d exp=44", a1); end
        checks++; if (d1 !== rom_val(18'd44)) begin failures++; $display("FAIL hold_data got=%h exp=%h", d1, rom_val(18'd44)); end
    endtask

    task automatic test_pause();
        logic [AW-1:0] a; logic [7:0] d; int lat;
        pulse_restart();
        speed = 8'h10;
        tick_collect(a, d, lat);                  // pos now 45
        enable = 1'b0;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.sample_valid !== 1'b0) begin failures++; $display("FAIL pause_valid got=%b exp=0", bus.sample_valid); end
        checks++; if (bus.mem_addr !== 18'd44) begin failures++; $display("FAIL pause_addr got=%0d exp=44", bus.mem_addr); end
        enable = 1'b1;
        tick_collect(a, d, lat);
        checks++; if (a !== 18'd45) begin failures++; $display("FAIL pause_resume got=%0d exp=45", a); end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a; logic [7:0] d; int lat; logic seen;
        speed = 8'h10; bus.sample_ready = 1'b1;
        @(negedge clk); sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;       // FETCH
        @(negedge clk);                           // WAIT
        rst_n = 1'b0; #1;
        checks++; if (bus.sample_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.sample_valid); end
        checks++; if (bus.sample_out !== 8'h80) begin failures++; $display("FAIL rstmid_sample got=%h exp=80", bus.sample_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (bus.sample_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_partial got=%b exp=0", seen); end
        tick_collect(a, d, lat);
        checks++; if (a !== 18'd44) begin failures++; $display("FAIL rstmid_first got=%0d exp=44", a); end
        checks++; if (d !== rom_val(18'd44)) begin failures++; $display("FAIL rstmid_data got=%h exp=%h", d, rom_val(18'd44)); end
    endtask

    initial begin
        bus.sample_ready = 1'b1;
        test_reset();
        test_unity();
        test_frac_speed();
        test_wrap();
        test_overrun();
        test_restart_tick();
        test_speed_zero();
        test_pause();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
